// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   ctrl_state_e  : sequencer states
//   hazard_ctrl_t : bundle of pipeline-register enable / flush / bubble / redirect controls
//   NopInstr      : encoding loaded into IF/ID on a flush (addi x0, x0, 0)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StDrain,
    StHalted
  } ctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_bubble;
    logic redirect_vld;
  } hazard_ctrl_t;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Free-running pipeline: every register loads, nothing squashed.
  function automatic hazard_ctrl_t ctrl_run();
    hazard_ctrl_t c;
    c               = '0;
    c.pc_we         = 1'b1;
    c.if_id_we      = 1'b1;
    c.id_ex_we      = 1'b1;
    c.ex_mem_we     = 1'b1;
    return c;
  endfunction

  // Data-memory wait: hold everything up to EX/MEM, feed a bubble into MEM/WB.
  function automatic hazard_ctrl_t ctrl_freeze();
    hazard_ctrl_t c;
    c               = '0;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the instruction in IF/ID reads the
// destination of a load currently in ID/EX (x0 never hazards).
//   id_rs1_i/id_rs2_i, id_use_rs1_i/id_use_rs2_i : IF/ID sources and their read-enables
//   ex_rd_i, ex_memread_i                         : ID/EX destination and load flag
//   load_use_o                                    : hazard flag
module load_use_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       load_use_o
);

  logic hit_rs1, hit_rs2;

  assign hit_rs1    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign hit_rs2    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_memread_i && (ex_rd_i != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Inputs : hazard sources (load-use operands, mispredict + target, dmem handshake, halt).
// Outputs: per-register enables/flushes/bubble, PC redirect, halted, sticky mem_timeout_o,
//          saturating stall_cnt_o / flush_cnt_o.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CntW       = 32,
  parameter int unsigned MemTimeout = 64,
  parameter int unsigned DrainCyc   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_memread_i,
  input  logic            ex_mispredict_i,
  input  logic [31:0]     ex_target_pc_i,
  input  logic            mem_req_i,
  input  logic            dmem_ready_i,
  input  logic            halt_req_i,
  output logic            pc_we_o,
  output logic            if_id_we_o,
  output logic            if_id_flush_o,
  output logic            id_ex_we_o,
  output logic            id_ex_flush_o,
  output logic            ex_mem_we_o,
  output logic            mem_wb_bubble_o,
  output logic            redirect_vld_o,
  output logic [31:0]     redirect_pc_o,
  output logic            halted_o,
  output logic            mem_timeout_o,
  output logic [CntW-1:0] stall_cnt_o,
  output logic [CntW-1:0] flush_cnt_o
);

  localparam int unsigned WaitW  = $clog2(MemTimeout + 1) + 1;
  localparam int unsigned DrainW = $clog2(DrainCyc) + 1;
  localparam logic [WaitW-1:0]  WaitLimit = WaitW'(MemTimeout);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCyc - 1);

  ctrl_state_e       state_q, state_d;
  hazard_ctrl_t      ctrl;
  logic              load_use, mem_stall;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;

  load_use_detect u_load_use_detect (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_memread_i (ex_memread_i),
    .load_use_o   (load_use)
  );

  assign mem_stall = mem_req_i && !dmem_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StRun;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall)                                          state_d = StMemWait;
        else if (!ex_mispredict_i && !load_use && halt_req_i)   state_d = StDrain;
      end
      StMemWait: if (dmem_ready_i)                              state_d = StRun;
      StDrain:   if (!mem_stall && drain_cnt_q == DrainLast)    state_d = StHalted;
      StHalted:  state_d = StHalted;
    endcase
  end

  // Control outputs
  always_comb begin
    ctrl = ctrl_run();
    unique case (state_q)
      StRun, StMemWait: begin
        // The exit cycle of a memory wait resolves like RUN but never starts a drain:
        // the halting instruction is still frozen in ID and will pulse again.
        if ((state_q == StRun) ? mem_stall : !dmem_ready_i) begin
          ctrl = ctrl_freeze();
        end else if (ex_mispredict_i) begin
          ctrl.redirect_vld = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_flush  = 1'b1;
        end else if (load_use) begin
          ctrl.pc_we        = 1'b0;
          ctrl.if_id_we     = 1'b0;
          ctrl.id_ex_flush  = 1'b1;
        end else if (state_q == StRun && halt_req_i) begin
          ctrl.pc_we        = 1'b0;
          ctrl.if_id_flush  = 1'b1;
        end
      end
      StDrain: begin
        if (mem_stall) ctrl = ctrl_freeze();
        else if (ex_mispredict_i) ctrl.id_ex_flush = 1'b1;  // squash wrong path, no redirect
        ctrl.pc_we       = 1'b0;
        ctrl.if_id_flush = 1'b1;
      end
      StHalted: ctrl = '0;
    endcase
    if (!rst_ni) ctrl = ctrl_run();
  end

  // Wait / drain / performance counters
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      StRun: begin
        if (mem_stall) wait_cnt_d = WaitW'(1);
        if (state_d == StDrain) drain_cnt_d = '0;
      end
      StMemWait: begin
        if (!dmem_ready_i) begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WaitLimit) mem_timeout_d = 1'b1;
        end
      end
      StDrain: if (!mem_stall) drain_cnt_d = drain_cnt_q + 1'b1;
      default: ;
    endcase
    if (!ctrl.pc_we && state_q != StHalted && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ctrl.redirect_vld && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign pc_we_o         = ctrl.pc_we;
  assign if_id_we_o      = ctrl.if_id_we;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_ex_we_o      = ctrl.id_ex_we;
  assign id_ex_flush_o   = ctrl.id_ex_flush;
  assign ex_mem_we_o     = ctrl.ex_mem_we;
  assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
  assign redirect_vld_o  = ctrl.redirect_vld;
  assign redirect_pc_o   = ctrl.redirect_vld ? ex_target_pc_i : 32'h0;
  assign halted_o        = (state_q == StHalted);
  assign mem_timeout_o   = mem_timeout_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW       = 8;
  localparam int unsigned TimeoutCyc = 4;
  localparam int unsigned DrainLen   = 4;
  localparam int          CntMax     = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_memread, ex_mispredict;
  logic [31:0]     ex_target_pc;
  logic            mem_req, dmem_ready, halt_req;
  logic            pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
  logic            mem_wb_bubble, redirect_vld, halted, mem_timeout;
  logic [31:0]     redirect_pc;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .CntW       (CntW),
    .MemTimeout (TimeoutCyc),
    .DrainCyc   (DrainLen)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_use_rs1_i    (id_use_rs1),
    .id_use_rs2_i    (id_use_rs2),
    .ex_rd_i         (ex_rd),
    .ex_memread_i    (ex_memread),
    .ex_mispredict_i (ex_mispredict),
    .ex_target_pc_i  (ex_target_pc),
    .mem_req_i       (mem_req),
    .dmem_ready_i    (dmem_ready),
    .halt_req_i      (halt_req),
    .pc_we_o         (pc_we),
    .if_id_we_o      (if_id_we),
    .if_id_flush_o   (if_id_flush),
    .id_ex_we_o      (id_ex_we),
    .id_ex_flush_o   (id_ex_flush),
    .ex_mem_we_o     (ex_mem_we),
    .mem_wb_bubble_o (mem_wb_bubble),
    .redirect_vld_o  (redirect_vld),
    .redirect_pc_o   (redirect_pc),
    .halted_o        (halted),
    .mem_timeout_o   (mem_timeout),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  typedef struct {
    bit          rst_n;
    logic [4:0]  rs1, rs2, rd;
    bit          use1, use2, memread, mispredict, mem_req, dmem_ready, halt;
    logic [31:0] tpc;
  } stim_t;

  typedef struct {
    bit          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, bubble, redirect;
    logic [31:0] rpc;
    bit          halted, timeout;
    int          stalls, flushes;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: pipeline situation described by "waiting on memory",
  // "draining with N cycles done", "halted", plus plain integer counters.
  bit m_wait, m_drain, m_halt, m_tmo;
  int m_waited, m_drained, m_stalls, m_flushes;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst_n = 1'b1; s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.use1 = 1'b0; s.use2 = 1'b0;
    s.memread = 1'b0; s.mispredict = 1'b0; s.mem_req = 1'b0; s.dmem_ready = 1'b0;
    s.halt = 1'b0; s.tpc = '0;
    return s;
  endfunction

  function automatic exp_t model_step(stim_t s);
    exp_t x;
    bit   lu, busy;
    x.pc_we = 1; x.if_id_we = 1; x.id_ex_we = 1; x.ex_mem_we = 1;
    x.if_id_flush = 0; x.id_ex_flush = 0; x.bubble = 0; x.redirect = 0; x.rpc = '0;
    if (!s.rst_n) begin
      m_wait = 0; m_drain = 0; m_halt = 0; m_tmo = 0;
      m_waited = 0; m_drained = 0; m_stalls = 0; m_flushes = 0;
      x.halted = 0; x.timeout = 0; x.stalls = 0; x.flushes = 0;
      return x;
    end
    x.halted = m_halt; x.timeout = m_tmo; x.stalls = m_stalls; x.flushes = m_flushes;
    lu = s.memread && s.rd != 0 && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    if (m_halt) begin
      x.pc_we = 0; x.if_id_we = 0; x.id_ex_we = 0; x.ex_mem_we = 0;
    end else if (m_drain) begin
      x.pc_we = 0; x.if_id_flush = 1;
      if (s.mem_req && !s.dmem_ready) begin
        x.if_id_we = 0; x.id_ex_we = 0; x.ex_mem_we = 0; x.bubble = 1;
      end else begin
        if (s.mispredict) x.id_ex_flush = 1;
        m_drained++;
        if (m_drained == DrainLen) begin m_drain = 0; m_halt = 1; end
      end
    end else begin
      busy = m_wait ? !s.dmem_ready : (s.mem_req && !s.dmem_ready);
      if (busy) begin
        x.pc_we = 0; x.if_id_we = 0; x.id_ex_we = 0; x.ex_mem_we = 0; x.bubble = 1;
        m_waited++;
        if (m_waited > TimeoutCyc) m_tmo = 1;  // still outstanding after TimeoutCyc cycles
      end else begin
        if (s.mispredict) begin
          x.redirect = 1; x.if_id_flush = 1; x.id_ex_flush = 1;
        end else if (lu) begin
          x.pc_we = 0; x.if_id_we = 0; x.id_ex_flush = 1;
        end else if (s.halt && !m_wait) begin
          x.pc_we = 0; x.if_id_flush = 1; m_drain = 1; m_drained = 0;
        end
        m_waited = 0;
      end
      m_wait = busy;
    end
    if (x.redirect) x.rpc = s.tpc;
    if (!x.pc_we && !x.halted && m_stalls < CntMax) m_stalls++;
    if (x.redirect && m_flushes < CntMax) m_flushes++;
    return x;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    ex_rd = s.rd; ex_memread = s.memread; ex_mispredict = s.mispredict; ex_target_pc = s.tpc;
    mem_req = s.mem_req; dmem_ready = s.dmem_ready; halt_req = s.halt;
    exp_q.push_back(model_step(s));
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Scoreboard monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("pc_we",         32'(pc_we),         32'(e.pc_we));
      cmp("if_id_we",      32'(if_id_we),      32'(e.if_id_we));
      cmp("if_id_flush",   32'(if_id_flush),   32'(e.if_id_flush));
      cmp("id_ex_we",      32'(id_ex_we),      32'(e.id_ex_we));
      cmp("id_ex_flush",   32'(id_ex_flush),   32'(e.id_ex_flush));
      cmp("ex_mem_we",     32'(ex_mem_we),     32'(e.ex_mem_we));
      cmp("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e.bubble));
      cmp("redirect_vld",  32'(redirect_vld),  32'(e.redirect));
      cmp("redirect_pc",   redirect_pc,        e.rpc);
      cmp("halted",        32'(halted),        32'(e.halted));
      cmp("mem_timeout",   32'(mem_timeout),   32'(e.timeout));
      cmp("stall_cnt",     32'(stall_cnt),     32'(e.stalls));
      cmp("flush_cnt",     32'(flush_cnt),     32'(e.flushes));
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    stim_t s;
    s = idle_stim();
    s.rst_n = 1'b0;
    repeat (n) apply(s);
  endtask

  function automatic stim_t rand_stim(input bit allow_halt);
    stim_t s;
    s = idle_stim();
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.use1 = ($urandom_range(0, 1) == 1); s.use2 = ($urandom_range(0, 1) == 1);
    s.memread    = ($urandom_range(0, 99) < 50);
    s.mispredict = ($urandom_range(0, 99) < 30);
    s.tpc        = $urandom();
    s.mem_req    = ($urandom_range(0, 99) < 35) || m_wait;
    s.dmem_ready = ($urandom_range(0, 99) < 55);
    s.halt       = allow_halt && ($urandom_range(0, 99) < 4);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = '0;
    ex_memread = 0; ex_mispredict = 0; ex_target_pc = '0; mem_req = 0; dmem_ready = 0;
    halt_req = 0;
    do_reset(2);

    // T1: lw x5 in EX, add x6,x5,x1 in ID -> one stall cycle
    s = idle_stim(); s.memread = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1; s.rs2 = 5'd1; s.use2 = 1;
    apply(s);
    settle(); cmp("t1_pc_we", 32'(pc_we), 0); cmp("t1_id_ex_flush", 32'(id_ex_flush), 1);
    apply(idle_stim());
    settle(); cmp("t1_stall_cnt", 32'(stall_cnt), 1); cmp("t1_pc_we_after", 32'(pc_we), 1);

    // T2: load to x0 never hazards
    s = idle_stim(); s.memread = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.use1 = 1;
    apply(s);
    settle(); cmp("t2_pc_we", 32'(pc_we), 1);
    apply(idle_stim());
    settle(); cmp("t2_stall_cnt", 32'(stall_cnt), 1);

    // T3: 3-cycle memory wait
    do_reset(1);
    s = idle_stim(); s.mem_req = 1;
    repeat (3) apply(s);
    s.dmem_ready = 1; apply(s);
    apply(idle_stim());
    settle(); cmp("t3_stall_cnt", 32'(stall_cnt), 3); cmp("t3_ex_mem_we", 32'(ex_mem_we), 1);
    cmp("t3_timeout", 32'(mem_timeout), 0);

    // T4: mispredict redirect
    s = idle_stim(); s.mispredict = 1; s.tpc = 32'h0000_0040;
    apply(s);
    settle(); cmp("t4_redirect_pc", redirect_pc, 32'h40); cmp("t4_if_id_flush", 32'(if_id_flush), 1);
    apply(idle_stim());
    settle(); cmp("t4_flush_cnt", 32'(flush_cnt), 1);

    // T5: mispredict held through a 2-cycle wait -> one redirect
    do_reset(1);
    s = idle_stim(); s.mem_req = 1; s.mispredict = 1; s.tpc = 32'h0000_0080;
    apply(s); apply(s);
    settle(); cmp("t5_no_redirect_in_wait", 32'(redirect_vld), 0);
    s.dmem_ready = 1; apply(s);
    settle(); cmp("t5_redirect_on_exit", 32'(redirect_vld), 1);
    apply(idle_stim());
    settle(); cmp("t5_flush_cnt", 32'(flush_cnt), 1); cmp("t5_stall_cnt", 32'(stall_cnt), 2);

    // T6: halt -> 4 drain cycles -> halted
    do_reset(1);
    s = idle_stim(); s.halt = 1; apply(s);
    repeat (DrainLen) apply(idle_stim());
    settle(); cmp("t6_not_yet_halted", 32'(halted), 0);
    apply(idle_stim());
    settle(); cmp("t6_halted", 32'(halted), 1); cmp("t6_ex_mem_we", 32'(ex_mem_we), 0);
    repeat (2) apply(idle_stim());
    settle(); cmp("t6_stall_cnt", 32'(stall_cnt), 5);

    // Timeout boundary: 4-cycle stall does not trip, 5-cycle stall does
    do_reset(1);
    s = idle_stim(); s.mem_req = 1;
    repeat (TimeoutCyc) apply(s);
    s.dmem_ready = 1; apply(s);
    apply(idle_stim());
    settle(); cmp("tmo_at_limit", 32'(mem_timeout), 0);
    s.dmem_ready = 0;
    repeat (TimeoutCyc + 1) apply(s);
    s.dmem_ready = 1; apply(s);
    repeat (2) apply(idle_stim());
    settle(); cmp("tmo_past_limit", 32'(mem_timeout), 1);

    // Reset mid-drain, with hazards present while reset is held
    do_reset(1);
    s = idle_stim(); s.halt = 1; apply(s);
    repeat (2) apply(idle_stim());
    s = idle_stim(); s.rst_n = 0; s.mem_req = 1; s.mispredict = 1; s.tpc = 32'h1234;
    apply(s);
    settle(); cmp("rst_halted", 32'(halted), 0); cmp("rst_pc_we", 32'(pc_we), 1);
    cmp("rst_redirect", 32'(redirect_vld), 0);
    repeat (2) apply(idle_stim());
    settle(); cmp("rst_run_pc_we", 32'(pc_we), 1); cmp("rst_stall_cnt", 32'(stall_cnt), 0);

    // Random, no halts: long enough to saturate the stall counter
    do_reset(1);
    repeat (3000) apply(rand_stim(1'b0));
    settle(); cmp("sat_stall_cnt", 32'(stall_cnt), CntMax);

    // Random with halts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim(1'b1);
      if ($urandom_range(0, 99) < 1 || (m_halt && $urandom_range(0, 99) < 25)) s.rst_n = 0;
      apply(s);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
